// File: rtl/nibble_alu_seq_pkg.sv
// Shared types and constants for the sequential packed-nibble add/sub unit.
package nibble_alu_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } alu_state_t;

  typedef enum logic {
    MODE_PACKED  = 1'b0,
    MODE_CHAINED = 1'b1
  } alu_mode_t;

  localparam logic [NIBBLE_W-1:0] NIB_SAT_POS = 4'h7;
  localparam logic [NIBBLE_W-1:0] NIB_SAT_NEG = 4'h8;

  // Overflow with a negative-looking raw sum means the true value ran off the positive end.
  function automatic logic [NIBBLE_W-1:0] sat_nibble(input logic [NIBBLE_W-1:0] raw,
                                                     input logic ovf);
    logic [NIBBLE_W-1:0] res;
    if (ovf) begin
      res = raw[NIBBLE_W-1] ? NIB_SAT_POS : NIB_SAT_NEG;
    end else begin
      res = raw;
    end
    return res;
  endfunction

endpackage

// File: rtl/nibble_alu_seq_if.sv
// Operand/result handshake bundle between register-read, the ALU and writeback.
interface nibble_alu_seq_if #(
  parameter int NIBBLES = 4
);
  import nibble_alu_pkg::*;

  localparam int DATA_W = NIBBLE_W * NIBBLES;

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] a;
  logic [DATA_W-1:0] b;
  logic              sub;
  logic              mode;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] result;
  logic              flag_v;
  logic              flag_n;
  logic              flag_z;

  modport master (
    output in_valid, a, b, sub, mode, out_ready,
    input  in_ready, out_valid, result, flag_v, flag_n, flag_z
  );

  modport slave (
    input  in_valid, a, b, sub, mode, out_ready,
    output in_ready, out_valid, result, flag_v, flag_n, flag_z
  );

endinterface

// File: rtl/nibble_alu_seq_add_raw.sv
// Combinational 4-bit carry-lookahead adder; raw sum, carry-out and signed overflow, no saturation.
module nibble_add_raw
  import nibble_alu_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a_i,
  input  logic [NIBBLE_W-1:0] b_i,
  input  logic                cin_i,
  output logic [NIBBLE_W-1:0] sum_o,
  output logic                cout_o,
  output logic                ovf_o
);

  logic [NIBBLE_W-1:0] g_s;
  logic [NIBBLE_W-1:0] p_s;
  logic [NIBBLE_W:0]   c_s;

  assign g_s = a_i & b_i;
  assign p_s = a_i ^ b_i;

  assign c_s[0] = cin_i;
  assign c_s[1] = g_s[0] | (p_s[0] & cin_i);
  assign c_s[2] = g_s[1] | (p_s[1] & g_s[0]) | (p_s[1] & p_s[0] & cin_i);
  assign c_s[3] = g_s[2] | (p_s[2] & g_s[1]) | (p_s[2] & p_s[1] & g_s[0])
                | (p_s[2] & p_s[1] & p_s[0] & cin_i);
  assign c_s[4] = g_s[3] | (p_s[3] & g_s[2]) | (p_s[3] & p_s[2] & g_s[1])
                | (p_s[3] & p_s[2] & p_s[1] & g_s[0])
                | (p_s[3] & p_s[2] & p_s[1] & p_s[0] & cin_i);

  assign sum_o  = p_s ^ c_s[NIBBLE_W-1:0];
  assign cout_o = c_s[NIBBLE_W];
  assign ovf_o  = c_s[NIBBLE_W-1] ^ c_s[NIBBLE_W];

endmodule

// File: rtl/nibble_alu_seq.sv
// Sequential saturating add/sub: one shared nibble adder walks the operands LSB first.
// Optional sticky saturation flag enabled by defining NIBBLE_ALU_SAT_STICKY_EN.
module nibble_alu_seq
  import nibble_alu_pkg::*;
#(
  parameter int NIBBLES = 4
) (
  input  logic clk,
  input  logic rst,
`ifdef NIBBLE_ALU_SAT_STICKY_EN
  output logic sat_sticky,
  input  logic sticky_clr,
`endif
  nibble_alu_seq_if.slave bus
);

  localparam int DATA_W = NIBBLE_W * NIBBLES;
  localparam int IDX_W  = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam int SH_W   = IDX_W + 2;

  alu_state_t        state_q, state_d;
  alu_mode_t         mode_q, mode_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              carry_q, carry_d;
  logic              sub_q, sub_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] b_q, b_d;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic              vacc_q, vacc_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic              flag_v_q, flag_v_d;
  logic              flag_n_q, flag_n_d;
  logic              flag_z_q, flag_z_d;
  logic              in_ready_q, in_ready_d;
  logic              out_valid_q, out_valid_d;

  logic [SH_W-1:0]     sh_s;
  logic [DATA_W-1:0]   a_shift_s;
  logic [DATA_W-1:0]   b_shift_s;
  logic [NIBBLE_W-1:0] a_nib_s;
  logic [NIBBLE_W-1:0] b_eff_s;
  logic                cin_s;
  logic [NIBBLE_W-1:0] raw_s;
  logic                cout_s;
  logic                ovf_s;
  logic [NIBBLE_W-1:0] nib_wr_s;
  logic [DATA_W-1:0]   merged_s;
  logic [DATA_W-1:0]   sat_full_s;
  logic [DATA_W-1:0]   final_s;
  logic                last_s;

  assign sh_s      = {idx_q, 2'b00};
  assign a_shift_s = a_q >> sh_s;
  assign b_shift_s = b_q >> sh_s;
  assign a_nib_s   = a_shift_s[NIBBLE_W-1:0];
  assign b_eff_s   = b_shift_s[NIBBLE_W-1:0] ^ {NIBBLE_W{sub_q}};
  // Chained lanes ripple through the carry register; packed lanes all restart from sub.
  assign cin_s     = (mode_q == MODE_CHAINED) ? carry_q : sub_q;

  nibble_add_raw u_add (
    .a_i    (a_nib_s),
    .b_i    (b_eff_s),
    .cin_i  (cin_s),
    .sum_o  (raw_s),
    .cout_o (cout_s),
    .ovf_o  (ovf_s)
  );

  assign nib_wr_s   = (mode_q == MODE_PACKED) ? sat_nibble(raw_s, ovf_s) : raw_s;
  assign merged_s   = (acc_q & ~(DATA_W'(4'hF) << sh_s)) | (DATA_W'(nib_wr_s) << sh_s);
  // On full-width overflow A and effective B share a sign, so A's sign picks the rail.
  assign sat_full_s = a_q[DATA_W-1] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
  assign final_s    = ((mode_q == MODE_CHAINED) && ovf_s) ? sat_full_s : merged_s;
  assign last_s     = (idx_q == IDX_W'(NIBBLES - 1));

  // Next-state and datapath update for the IDLE/RUN/DONE sequencer.
  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    idx_d       = idx_q;
    carry_d     = carry_q;
    sub_d       = sub_q;
    a_d         = a_q;
    b_d         = b_q;
    acc_d       = acc_q;
    vacc_d      = vacc_q;
    result_d    = result_q;
    flag_v_d    = flag_v_q;
    flag_n_d    = flag_n_q;
    flag_z_d    = flag_z_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid && in_ready_q) begin
          a_d        = bus.a;
          b_d        = bus.b;
          sub_d      = bus.sub;
          mode_d     = alu_mode_t'(bus.mode);
          idx_d      = '0;
          carry_d    = bus.sub;
          acc_d      = '0;
          vacc_d     = 1'b0;
          in_ready_d = 1'b0;
          state_d    = RUN;
        end else begin
          in_ready_d = 1'b1;
        end
      end
      RUN: begin
        acc_d   = merged_s;
        carry_d = cout_s;
        vacc_d  = vacc_q | ovf_s;
        idx_d   = idx_q + IDX_W'(1);
        if (last_s) begin
          result_d    = final_s;
          flag_v_d    = (mode_q == MODE_PACKED) ? (vacc_q | ovf_s) : ovf_s;
          flag_n_d    = final_s[DATA_W-1];
          flag_z_d    = (final_s == '0);
          idx_d       = '0;
          out_valid_d = 1'b1;
          state_d     = DONE;
        end else begin
          state_d = RUN;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
        state_d     = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset discards any in-flight operation.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      mode_q      <= MODE_PACKED;
      idx_q       <= '0;
      carry_q     <= 1'b0;
      sub_q       <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      acc_q       <= '0;
      vacc_q      <= 1'b0;
      result_q    <= '0;
      flag_v_q    <= 1'b0;
      flag_n_q    <= 1'b0;
      flag_z_q    <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      idx_q       <= idx_d;
      carry_q     <= carry_d;
      sub_q       <= sub_d;
      a_q         <= a_d;
      b_q         <= b_d;
      acc_q       <= acc_d;
      vacc_q      <= vacc_d;
      result_q    <= result_d;
      flag_v_q    <= flag_v_d;
      flag_n_q    <= flag_n_d;
      flag_z_q    <= flag_z_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.flag_v    = flag_v_q;
  assign bus.flag_n    = flag_n_q;
  assign bus.flag_z    = flag_z_q;

`ifdef NIBBLE_ALU_SAT_STICKY_EN
  logic sticky_q, sticky_d;
  logic retire_s;

  assign retire_s = out_valid_q && bus.out_ready;

  // Sticky saturation: a saturating retire beats a simultaneous clear.
  always_comb begin
    sticky_d = sticky_q;
    if (retire_s && flag_v_q) begin
      sticky_d = 1'b1;
    end else if (sticky_clr) begin
      sticky_d = 1'b0;
    end else begin
      sticky_d = sticky_q;
    end
  end

  // Sticky flag register.
  always_ff @(posedge clk) begin
    if (rst) begin
      sticky_q <= 1'b0;
    end else begin
      sticky_q <= sticky_d;
    end
  end

  assign sat_sticky = sticky_q;
`endif

endmodule

// File: tb/tb_nibble_alu_seq.sv
// Self-checking bench for nibble_alu_seq: directed plan cases plus random ops against a signed-arithmetic model.
module tb_nibble_alu_seq;
  import nibble_alu_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  nibble_alu_seq_if #(.NIBBLES(4)) bus ();

`ifdef NIBBLE_ALU_SAT_STICKY_EN
  logic sat_sticky;
  logic sticky_clr;
`endif

  nibble_alu_seq #(.NIBBLES(4)) dut (
    .clk        (clk),
    .rst        (rst),
`ifdef NIBBLE_ALU_SAT_STICKY_EN
    .sat_sticky (sat_sticky),
    .sticky_clr (sticky_clr),
`endif
    .bus        (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: true signed sum/difference clamped to the representable range.
  function automatic void model(input logic [15:0] ma, input logic [15:0] mb,
                                input logic ms, input logic mm,
                                output logic [15:0] r, output logic v);
    int x, y, s;
    logic [3:0] la, lb;
    r = 16'h0000;
    v = 1'b0;
    if (mm) begin
      x = int'($signed(ma));
      y = int'($signed(mb));
      s = ms ? (x - y) : (x + y);
      if (s > 32767) begin
        r = 16'h7FFF; v = 1'b1;
      end else if (s < -32768) begin
        r = 16'h8000; v = 1'b1;
      end else begin
        r = s[15:0];
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        la = ma[i*4 +: 4];
        lb = mb[i*4 +: 4];
        x = int'($signed(la));
        y = int'($signed(lb));
        s = ms ? (x - y) : (x + y);
        if (s > 7) begin
          r[i*4 +: 4] = 4'h7; v = 1'b1;
        end else if (s < -8) begin
          r[i*4 +: 4] = 4'h8; v = 1'b1;
        end else begin
          r[i*4 +: 4] = s[3:0];
        end
      end
    end
  endfunction

  task automatic run_op(input logic [15:0] ta, input logic [15:0] tb2, input logic ts,
                        input logic tm, input int hold, input logic clr_ret);
    logic [15:0] er;
    logic        ev;
    int          lat;
    int          w;
    model(ta, tb2, ts, tm, er, ev);
    w = 0;
    while (!bus.in_ready && w < 20) begin
      @(posedge clk); #1; w++;
    end
    check("in_ready_idle", 32'(bus.in_ready), 32'd1);
    bus.a = ta; bus.b = tb2; bus.sub = ts; bus.mode = tm; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    // Keep a stray request with garbage operands up while busy; it must be ignored.
    bus.a = 16'($urandom); bus.b = 16'($urandom); bus.sub = ~ts; bus.mode = ~tm;
    check("in_ready_busy", 32'(bus.in_ready), 32'd0);
    lat = 0;
    while (!bus.out_valid && lat < 20) begin
      @(posedge clk); #1; lat++;
    end
    bus.in_valid = 1'b0;
    check("latency", 32'(lat), 32'd4);
    for (int h = 0; h <= hold; h++) begin
      check("result", 32'(bus.result), 32'(er));
      check("flag_v", 32'(bus.flag_v), 32'(ev));
      check("flag_n", 32'(bus.flag_n), 32'(er[15]));
      check("flag_z", 32'(bus.flag_z), 32'(er == 16'h0000));
      check("done_in_ready", 32'(bus.in_ready), 32'd0);
      check("done_valid", 32'(bus.out_valid), 32'd1);
      if (h < hold) begin
        @(posedge clk); #1;
      end
    end
    bus.out_ready = 1'b1;
`ifdef NIBBLE_ALU_SAT_STICKY_EN
    sticky_clr = clr_ret;
`endif
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
`ifdef NIBBLE_ALU_SAT_STICKY_EN
    sticky_clr = 1'b0;
`endif
    check("retire_valid", 32'(bus.out_valid), 32'd0);
    check("retire_in_ready", 32'(bus.in_ready), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    bus.in_valid = 1'b0; bus.a = 16'h0000; bus.b = 16'h0000;
    bus.sub = 1'b0; bus.mode = 1'b0; bus.out_ready = 1'b0;
`ifdef NIBBLE_ALU_SAT_STICKY_EN
    sticky_clr = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_result", 32'(bus.result), 32'd0);
    check("rst_flags", 32'({bus.flag_v, bus.flag_n, bus.flag_z}), 32'd0);
`ifdef NIBBLE_ALU_SAT_STICKY_EN
    check("rst_sticky", 32'(sat_sticky), 32'd0);
`endif

    // Directed plan cases (one with 3 cycles of backpressure).
    run_op(16'h7123, 16'h1111, 1'b0, 1'b0, 0, 1'b0);
    check("packed_add_const", 32'(bus.result), 32'h7234);
    run_op(16'h8000, 16'h1001, 1'b1, 1'b0, 3, 1'b0);
    check("packed_sub_const", 32'(bus.result), 32'h800F);
    run_op(16'h1234, 16'h0FCC, 1'b0, 1'b1, 0, 1'b0);
    check("chain_add_const", 32'(bus.result), 32'h2200);
    run_op(16'h7FFF, 16'h0001, 1'b0, 1'b1, 2, 1'b0);
    run_op(16'h0005, 16'h0005, 1'b1, 1'b1, 0, 1'b0);
    run_op(16'h8000, 16'h0001, 1'b1, 1'b1, 1, 1'b0);
    check("chain_sub_sat_const", 32'(bus.result), 32'h8000);

    // Reset while RUN has processed two nibbles.
    bus.a = 16'h7777; bus.b = 16'h7777; bus.sub = 1'b0; bus.mode = 1'b1; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrun_rst_valid", 32'(bus.out_valid), 32'd0);
    check("midrun_rst_result", 32'(bus.result), 32'd0);
    check("midrun_rst_in_ready", 32'(bus.in_ready), 32'd1);
    repeat (6) @(posedge clk);
    #1;
    check("midrun_rst_no_output", 32'(bus.out_valid), 32'd0);

`ifdef NIBBLE_ALU_SAT_STICKY_EN
    run_op(16'h7FFF, 16'h0001, 1'b0, 1'b1, 0, 1'b0);
    check("sticky_set", 32'(sat_sticky), 32'd1);
    run_op(16'h1234, 16'h0FCC, 1'b0, 1'b1, 0, 1'b0);
    check("sticky_hold", 32'(sat_sticky), 32'd1);
    sticky_clr = 1'b1;
    @(posedge clk); #1;
    sticky_clr = 1'b0;
    check("sticky_clr", 32'(sat_sticky), 32'd0);
    run_op(16'h7FFF, 16'h0001, 1'b0, 1'b1, 0, 1'b1);
    check("sticky_set_wins", 32'(sat_sticky), 32'd1);
`endif

    // Random operands, modes and backpressure.
    for (int i = 0; i < 40; i++) begin
      run_op(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)), int'($urandom_range(0, 2)), 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
